// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sequencing controller:
// state encoding, check/evaluate edge offsets and legal oversampling ratios.
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Offsets from mid-bit (P/2): checkers are enabled at +2, their registered result is read at +3.
  localparam int E_CHK_OFS  = 2;
  localparam int E_EVAL_OFS = 3;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit position counter for the UART receiver.
// The edge counter wraps at prescale-1; the bit counter advances on request from the FSM.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cnt_en,
  input  logic                  i_start,
  input  logic                  i_bit_clr,
  input  logic                  i_bit_inc,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]      o_bit_cnt,
  output logic                  o_edge_last,
  output logic                  o_bit_done
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  edge_last;

  assign edge_last = (edge_cnt_q == i_prescale - PRESCALE_W'(1));

  always_comb begin
    edge_cnt_d = '0;
    // The start-detect cycle was edge 0, so the first START cycle is edge 1 whatever prescale says.
    if (i_cnt_en) begin
      if (i_start)        edge_cnt_d = PRESCALE_W'(1);
      else if (edge_last) edge_cnt_d = '0;
      else                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (i_bit_clr)      bit_cnt_d = '0;
    else if (i_bit_inc) bit_cnt_d = bit_cnt_q + BIT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign o_edge_cnt  = edge_cnt_q;
  assign o_bit_cnt   = bit_cnt_q;
  assign o_edge_last = edge_last;
  assign o_bit_done  = edge_last && (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencing controller: detects the start edge, pulses the checker and
// deserializer enables at the right oversampling edge, and strobes the frame verdict.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx_in,
  input  logic                          i_par_en,
  input  logic [PRESCALE_W-1:0]         i_prescale,
  input  logic                          i_start_glitch,
  input  logic                          i_parity_err,
  input  logic                          i_stop_bit_checked,
  output logic                          o_data_samp_en,
  output logic                          o_start_check_en,
  output logic                          o_parity_check_en,
  output logic                          o_stop_check_en,
  output logic                          o_deser_en,
  output logic [$clog2(DATA_WIDTH)-1:0] o_bit_idx,
  output logic                          o_data_valid,
  output logic                          o_parity_error,
  output logic                          o_framing_error
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stop_ok_q, stop_ok_d;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  edge_last, bit_done;
  logic [PRESCALE_W-1:0] e_chk, e_eval;
  logic                  at_chk, at_eval, idle_start, stop_end, stop_ok_eff;

  assign e_chk      = (prescale_q >> 1) + PRESCALE_W'(E_CHK_OFS);
  assign e_eval     = (prescale_q >> 1) + PRESCALE_W'(E_EVAL_OFS);
  assign at_chk     = (edge_cnt == e_chk);
  assign at_eval    = (edge_cnt == e_eval);
  assign idle_start = (state_q == ST_IDLE) && !i_rx_in;

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cnt_en    (state_d != ST_IDLE),
    .i_start     (idle_start),
    .i_bit_clr   (state_q != ST_DATA),
    .i_bit_inc   ((state_q == ST_DATA) && edge_last && !bit_done),
    .i_prescale  (prescale_q),
    .o_edge_cnt  (edge_cnt),
    .o_bit_cnt   (bit_cnt),
    .o_edge_last (edge_last),
    .o_bit_done  (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_fail_d = par_fail_q;
    stop_ok_d  = stop_ok_q;
    case (state_q)
      ST_IDLE: begin
        prescale_d = i_prescale;
        par_en_d   = i_par_en;
        if (!i_rx_in) state_d = ST_START;
      end
      ST_START: begin
        // With P=8 the evaluate edge is also the last edge; a glitch must win.
        if (at_eval && i_start_glitch) state_d = ST_IDLE;
        else if (edge_last)            state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (at_eval)   par_fail_d = i_parity_err;
        if (edge_last) state_d    = ST_STOP;
      end
      ST_STOP: begin
        if (at_eval) stop_ok_d = i_stop_bit_checked;
        if (edge_last) begin
          state_d    = ST_IDLE;
          par_fail_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      prescale_q <= PRESCALE_W'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_fail_q <= 1'b0;
      stop_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_fail_q <= par_fail_d;
      stop_ok_q  <= stop_ok_d;
    end
  end

  // When the evaluate edge coincides with the last edge (P=8) the stop result is used directly.
  assign stop_ok_eff = at_eval ? i_stop_bit_checked : stop_ok_q;
  assign stop_end    = (state_q == ST_STOP) && edge_last;

  assign o_data_samp_en    = (state_q != ST_IDLE) || (idle_start && i_rst_n);
  assign o_start_check_en  = (state_q == ST_START)  && at_chk;
  assign o_deser_en        = (state_q == ST_DATA)   && at_chk;
  assign o_parity_check_en = (state_q == ST_PARITY) && at_chk;
  assign o_stop_check_en   = (state_q == ST_STOP)   && at_chk;
  assign o_bit_idx         = (state_q == ST_DATA) ? bit_cnt : '0;
  assign o_framing_error   = stop_end && !stop_ok_eff;
  assign o_parity_error    = stop_end && stop_ok_eff && par_fail_q;
  assign o_data_valid      = stop_end && stop_ok_eff && !par_fail_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: drives whole serial frames and predicts every output cycle
// from the frame's bit/edge position, with small registered models of the checkers.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic [PW-1:0] prescale = PW'(8);
  logic          start_glitch, parity_err, stop_chk;
  logic          samp_en, start_en, par_chk_en, stop_en, deser_en;
  logic [2:0]    bit_idx;
  logic          data_valid, par_error, frm_error;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic [7:0]  cur_data = 8'h00;
  int t0, dv_cyc, cnt_deser, cnt_start, cnt_pc, cnt_sc, cnt_dv, cnt_pe, cnt_fe;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rx_in            (rx_in),
    .i_par_en           (par_en),
    .i_prescale         (prescale),
    .i_start_glitch     (start_glitch),
    .i_parity_err       (parity_err),
    .i_stop_bit_checked (stop_chk),
    .o_data_samp_en     (samp_en),
    .o_start_check_en   (start_en),
    .o_parity_check_en  (par_chk_en),
    .o_stop_check_en    (stop_en),
    .o_deser_en         (deser_en),
    .o_bit_idx          (bit_idx),
    .o_data_valid       (data_valid),
    .o_parity_error     (par_error),
    .o_framing_error    (frm_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered checker models: each captures the line when its enable is high (even parity).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_glitch <= 1'b0;
      parity_err   <= 1'b0;
      stop_chk     <= 1'b0;
    end else begin
      if (start_en)   start_glitch <= rx_in;
      if (par_chk_en) parity_err   <= rx_in ^ (^cur_data);
      if (stop_en)    stop_chk     <= rx_in;
    end
  end

  // Drives one frame and checks all outputs each cycle against the position-derived prediction.
  // glitch_len > 0: start bit low only that many cycles; rst_at >= 0: assert reset at that cycle.
  task automatic run_frame(input int p, input bit pe, input logic [7:0] d, input bit par_wrong,
                           input bit stop_v, input int glitch_len, input int rst_at,
                           input bit scramble, input string name);
    int nbits, echk, eeval, len;
    logic [10:0] expv, actv;
    nbits = pe ? 11 : 10;
    echk  = p / 2 + 2;
    eeval = echk + 1;
    len   = (glitch_len > 0) ? eeval + 1 : nbits * p;
    cur_data = d;
    cnt_deser = 0; cnt_start = 0; cnt_pc = 0; cnt_sc = 0;
    cnt_dv = 0; cnt_pe = 0; cnt_fe = 0; dv_cyc = -1;
    for (int k = 0; k < len; k++) begin
      int b, e;
      logic rxv;
      b = k / p;
      e = k % p;
      @(posedge clk); #1;
      if (k == 0) begin
        prescale = PW'(p);
        par_en   = pe;
        t0       = cyc;
      end else if (scramble && k == p + 1) begin
        prescale = PW'($urandom);
        par_en   = 1'($urandom);
      end
      if (b == 0)                  rxv = (glitch_len > 0 && k >= glitch_len);
      else if (b <= 8)             rxv = d[b-1];
      else if (pe && b == 9)       rxv = (^d) ^ par_wrong;
      else                         rxv = stop_v;
      rx_in = rxv;
      if (k == rst_at) rst_n = 1'b0;
      @(negedge clk);
      expv = '0;
      expv[10] = 1'b1;
      expv[9]  = (b == 0 && e == echk);
      expv[8]  = (pe && b == 9 && e == echk);
      expv[7]  = (b == nbits - 1 && e == echk);
      expv[6]  = (b >= 1 && b <= 8 && e == echk);
      expv[5:3] = (b >= 1 && b <= 8) ? 3'(b - 1) : 3'd0;
      if (glitch_len == 0 && k == nbits * p - 1) begin
        expv[2] = stop_v && !(pe && par_wrong);
        expv[1] = stop_v && pe && par_wrong;
        expv[0] = !stop_v;
      end
      if (k == rst_at) expv = '0;
      actv = {samp_en, start_en, par_chk_en, stop_en, deser_en, bit_idx,
              data_valid, par_error, frm_error};
      n_checks++;
      if (actv !== expv) begin
        n_fails++;
        $display("FAIL %s k=%0d outputs got=%b want=%b", name, k, actv, expv);
      end
      cnt_start += int'(start_en);
      cnt_deser += int'(deser_en);
      cnt_pc    += int'(par_chk_en);
      cnt_sc    += int'(stop_en);
      cnt_pe    += int'(par_error);
      cnt_fe    += int'(frm_error);
      if (data_valid === 1'b1) begin
        cnt_dv++;
        dv_cyc = cyc;
      end
      if (k == rst_at) break;
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    logic [10:0] actv;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_in = 1'b1;
      @(negedge clk);
      actv = {samp_en, start_en, par_chk_en, stop_en, deser_en, bit_idx,
              data_valid, par_error, frm_error};
      n_checks++;
      if (actv !== 11'd0) begin
        n_fails++;
        $display("FAIL %s idle cycle %0d outputs got=%b want=0", name, i, actv);
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] actv;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_in = (i == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      actv = {samp_en, start_en, par_chk_en, stop_en, deser_en, bit_idx,
              data_valid, par_error, frm_error};
      n_checks++;
      if (actv !== 11'd0) begin
        n_fails++;
        $display("FAIL reset_state cycle %0d outputs got=%b want=0", i, actv);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_in = 1'b1;
    idle_cycles(3, "post_reset_idle");
  endtask

  task automatic test_p8_a5();
    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b1, 0, -1, 1'b0, "p8_a5");
    n_checks++;
    if (cnt_deser != 8) begin
      n_fails++;
      $display("FAIL p8_a5_deser_count got=%0d want=8", cnt_deser);
    end
    n_checks++;
    if (cnt_dv != 1 || dv_cyc - t0 != 79) begin
      n_fails++;
      $display("FAIL p8_a5_valid_time pulses=%0d offset=%0d want 1 pulse at offset 79", cnt_dv, dv_cyc - t0);
    end
    idle_cycles(2, "p8_a5_after");
  endtask

  task automatic test_parity_error();
    run_frame(16, 1'b1, 8'h3B, 1'b1, 1'b1, 0, -1, 1'b0, "p16_parity");
    n_checks++;
    if (cnt_pc != 1 || cnt_pe != 1 || cnt_dv != 0) begin
      n_fails++;
      $display("FAIL p16_parity_counts pchk=%0d perr=%0d dv=%0d want 1/1/0", cnt_pc, cnt_pe, cnt_dv);
    end
    idle_cycles(2, "p16_parity_after");
  endtask

  task automatic test_glitch();
    run_frame(8, 1'b0, 8'h00, 1'b0, 1'b1, 3, -1, 1'b0, "p8_glitch");
    n_checks++;
    if (cnt_start != 1 || cnt_deser + cnt_pc + cnt_sc != 0) begin
      n_fails++;
      $display("FAIL glitch_enables start=%0d others=%0d want 1/0", cnt_start, cnt_deser + cnt_pc + cnt_sc);
    end
    idle_cycles(4, "glitch_back_to_idle");
  endtask

  task automatic test_framing_priority();
    run_frame(32, 1'b1, 8'h96, 1'b1, 1'b0, 0, -1, 1'b0, "p32_framing");
    n_checks++;
    if (cnt_fe != 1 || cnt_pe != 0 || cnt_dv != 0) begin
      n_fails++;
      $display("FAIL framing_priority ferr=%0d perr=%0d dv=%0d want 1/0/0", cnt_fe, cnt_pe, cnt_dv);
    end
    idle_cycles(2, "framing_back_to_idle");
  endtask

  task automatic test_back_to_back();
    int first_dv;
    run_frame(8, 1'b0, 8'h00, 1'b0, 1'b1, 0, -1, 1'b0, "b2b_first");
    first_dv = dv_cyc;
    run_frame(8, 1'b0, 8'hFF, 1'b0, 1'b1, 0, -1, 1'b0, "b2b_second");
    n_checks++;
    if (cnt_dv != 1 || dv_cyc - first_dv != 80) begin
      n_fails++;
      $display("FAIL b2b_spacing got=%0d want=80", dv_cyc - first_dv);
    end
    idle_cycles(1, "b2b_after");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8, 1'b0, 8'h2C, 1'b0, 1'b1, 0, 43, 1'b0, "mid_reset");
    idle_cycles(2, "mid_reset_held");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2, "mid_reset_released");
    run_frame(8, 1'b0, 8'h3C, 1'b0, 1'b1, 0, -1, 1'b0, "after_reset_frame");
    n_checks++;
    if (cnt_dv != 1 || dv_cyc - t0 != 79) begin
      n_fails++;
      $display("FAIL after_reset_valid pulses=%0d offset=%0d want 1 at 79", cnt_dv, dv_cyc - t0);
    end
  endtask

  task automatic test_illegal_prescale();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        prescale = PW'(4);
        par_en   = 1'b0;
        rx_in    = 1'b0;
      end else begin
        rx_in = 1'($urandom);
      end
    end
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      rx_in = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (samp_en !== 1'b0) begin
      n_fails++;
      $display("FAIL illegal_prescale_idle samp_en got=%b want=0", samp_en);
    end
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b1, 0, -1, 1'b0, "after_illegal");
    n_checks++;
    if (cnt_dv != 1) begin
      n_fails++;
      $display("FAIL after_illegal_valid pulses got=%0d want=1", cnt_dv);
    end
    idle_cycles(1, "after_illegal_idle");
  endtask

  task automatic test_random();
    int plist [3] = '{8, 16, 32};
    for (int n = 0; n < 20; n++) begin
      int p, gap;
      bit pe, pw, sv;
      logic [7:0] d;
      p   = plist[$urandom % 3];
      pe  = 1'($urandom);
      pw  = 1'($urandom);
      sv  = ($urandom % 4) != 0;
      d   = 8'($urandom);
      gap = $urandom % 3;
      run_frame(p, pe, d, pw, sv, 0, -1, 1'b1, "random");
      n_checks++;
      if (cnt_dv + cnt_pe + cnt_fe != 1) begin
        n_fails++;
        $display("FAIL random_one_strobe frame %0d got=%0d strobes want=1", n, cnt_dv + cnt_pe + cnt_fe);
      end
      idle_cycles(gap, "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_p8_a5();
    test_parity_error();
    test_glitch();
    test_framing_priority();
    test_back_to_back();
    test_reset_mid_frame();
    test_illegal_prescale();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
